// File: rtl/mm_read_frame_ctrl_if.sv
// AXI read-address and read-data channels between the frame read controller
// (master) and the memory port (slave).
interface mm_read_frame_ctrl_if #(
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int AXI_DSIZE = 256,
  parameter int IDSIZE    = 4
);
  logic [IDSIZE-1:0]    axi_arid;
  logic [ASIZE-1:0]     axi_araddr;
  logic [LSIZE-1:0]     axi_arlen;
  logic [2:0]           axi_arsize;
  logic [1:0]           axi_arburst;
  logic                 axi_arvalid;
  logic                 axi_arready;
  logic [IDSIZE-1:0]    axi_rid;
  logic [AXI_DSIZE-1:0] axi_rdata;
  logic [1:0]           axi_rresp;
  logic                 axi_rlast;
  logic                 axi_rvalid;
  logic                 axi_rready;

  modport master (
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );

  modport slave (
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );
endinterface

// File: rtl/mm_read_frame_ctrl.sv
// Frame reader: walks vactive lines of line_beats AXI beats each, one burst in
// flight at a time, and streams the read data straight through.
//
// state      | meaning
// IDLE       | waiting for start
// WAIT_SPACE | next burst sized, waiting for downstream FIFO room
// ADDR       | AR request presented, waiting for arready
// DATA       | accepting R beats until rlast
// NEXT       | advance beat/line counters
// FIN        | frame over; done pulses on the following cycle
module mm_read_frame_ctrl #(
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int AXI_DSIZE = 256,
  parameter int IDSIZE    = 4,
  parameter int ID        = 0,
  parameter int BURST_LEN = 128,
  parameter int LINE_STEP = 16384
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ASIZE-1:0]     baseaddr,
  input  logic [15:0]          vactive,
  input  logic [15:0]          line_beats,
  input  logic [9:0]           fifo_space,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  mm_read_frame_ctrl_if.master axi,
  output logic [AXI_DSIZE-1:0] odata,
  output logic                 ovalid,
  output logic                 ofirst,
  output logic                 olast
);

  localparam int          BYTES       = AXI_DSIZE / 8;
  localparam logic [15:0] BURST_LEN16 = 16'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, ADDR, DATA, NEXT, FIN} state_t;

  state_t           state_q, state_d;
  logic [15:0]      vact_q, vact_d;
  logic [15:0]      lbeats_q, lbeats_d;
  logic [15:0]      line_idx_q, line_idx_d;
  logic [15:0]      beats_done_q, beats_done_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic [15:0]      len_q, len_d;
  logic [ASIZE-1:0] line_start_q, line_start_d;
  logic [ASIZE-1:0] araddr_q, araddr_d;
  logic [LSIZE-1:0] arlen_q, arlen_d;
  logic             err_q, err_d;
  logic             first_q, first_d;
  logic             done_q, done_d;

  logic [15:0] remaining;
  logic [15:0] burst_len;
  logic [15:0] beat_num;
  logic        rid_unused;

  assign remaining  = lbeats_q - beats_done_q;
  assign burst_len  = (remaining > BURST_LEN16) ? BURST_LEN16 : remaining;
  assign beat_num   = beat_cnt_q + 16'd1;
  assign rid_unused = ^axi.axi_rid;

  always_comb begin
    state_d      = state_q;
    vact_d       = vact_q;
    lbeats_d     = lbeats_q;
    line_idx_d   = line_idx_q;
    beats_done_d = beats_done_q;
    beat_cnt_d   = beat_cnt_q;
    len_d        = len_q;
    line_start_d = line_start_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    err_d        = err_q;
    first_d      = first_q;
    done_d       = (state_q == FIN);
    case (state_q)
      IDLE: begin
        if (start) begin
          vact_d       = vactive;
          lbeats_d     = line_beats;
          line_start_d = baseaddr;
          line_idx_d   = '0;
          beats_done_d = '0;
          err_d        = 1'b0;
          first_d      = 1'b1;
          state_d      = (vactive == 16'd0 || line_beats == 16'd0) ? FIN : WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if ({6'd0, fifo_space} >= burst_len) begin
          len_d      = burst_len;
          araddr_d   = line_start_q + ASIZE'(beats_done_q) * ASIZE'(BYTES);
          arlen_d    = LSIZE'(burst_len - 16'd1);
          beat_cnt_d = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (axi.axi_arready) state_d = DATA;
      end
      DATA: begin
        if (axi.axi_rvalid) begin
          beat_cnt_d = beat_num;
          first_d    = 1'b0;
          if (axi.axi_rresp != 2'b00) err_d = 1'b1;
          // rlast always closes the burst; a misplaced or missing one only flags err
          if (axi.axi_rlast) begin
            if (beat_num != len_q) err_d = 1'b1;
            state_d = NEXT;
          end else if (beat_num == len_q) begin
            err_d = 1'b1;
          end
        end
      end
      NEXT: begin
        if ({1'b0, beats_done_q} + {1'b0, len_q} < {1'b0, lbeats_q}) begin
          beats_done_d = beats_done_q + len_q;
          state_d      = WAIT_SPACE;
        end else begin
          beats_done_d = '0;
          line_idx_d   = line_idx_q + 16'd1;
          line_start_d = line_start_q + ASIZE'(LINE_STEP);
          state_d      = (line_idx_q + 16'd1 == vact_q) ? FIN : WAIT_SPACE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vact_q       <= '0;
      lbeats_q     <= '0;
      line_idx_q   <= '0;
      beats_done_q <= '0;
      beat_cnt_q   <= '0;
      len_q        <= '0;
      line_start_q <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      err_q        <= 1'b0;
      first_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vact_q       <= vact_d;
      lbeats_q     <= lbeats_d;
      line_idx_q   <= line_idx_d;
      beats_done_q <= beats_done_d;
      beat_cnt_q   <= beat_cnt_d;
      len_q        <= len_d;
      line_start_q <= line_start_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      err_q        <= err_d;
      first_q      <= first_d;
      done_q       <= done_d;
    end
  end

  assign axi.axi_arid    = IDSIZE'(ID);
  assign axi.axi_araddr  = araddr_q;
  assign axi.axi_arlen   = arlen_q;
  assign axi.axi_arsize  = 3'($clog2(BYTES));
  assign axi.axi_arburst = 2'b01;
  assign axi.axi_arvalid = (state_q == ADDR);
  assign axi.axi_rready  = (state_q == DATA);

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign err    = err_q;
  assign odata  = axi.axi_rdata;
  assign ovalid = axi.axi_rvalid && (state_q == DATA);
  assign ofirst = ovalid && first_q;
  assign olast  = ovalid &&
                  ({1'b0, beats_done_q} + {1'b0, beat_cnt_q} + 17'd1 == {1'b0, lbeats_q});

endmodule

// File: tb/tb_mm_read_frame_ctrl.sv
// Bench for mm_read_frame_ctrl: randomized AXI slave plus a frame-level
// reference model of the expected AR sequence and stream markers.
module tb_mm_read_frame_ctrl;
  localparam int ASIZE = 29, LSIZE = 9, AXI_DSIZE = 256, IDSIZE = 4, ID = 0;
  localparam int BURST_LEN = 128, LINE_STEP = 16384, BYTES = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, start;
  logic [ASIZE-1:0]     baseaddr;
  logic [15:0]          vactive, line_beats;
  logic [9:0]           fifo_space;
  logic                 busy, done, err, ovalid, ofirst, olast;
  logic [AXI_DSIZE-1:0] odata;

  mm_read_frame_ctrl_if #(.ASIZE(ASIZE), .LSIZE(LSIZE), .AXI_DSIZE(AXI_DSIZE),
                          .IDSIZE(IDSIZE)) axi ();

  mm_read_frame_ctrl #(.ASIZE(ASIZE), .LSIZE(LSIZE), .AXI_DSIZE(AXI_DSIZE),
                       .IDSIZE(IDSIZE), .ID(ID), .BURST_LEN(BURST_LEN),
                       .LINE_STEP(LINE_STEP)) dut (
    .clock(clk), .rst(rst), .start(start), .baseaddr(baseaddr),
    .vactive(vactive), .line_beats(line_beats), .fifo_space(fifo_space),
    .busy(busy), .done(done), .err(err), .axi(axi),
    .odata(odata), .ovalid(ovalid), .ofirst(ofirst), .olast(olast));

  assign axi.axi_rid = IDSIZE'(ID);

  int n_assert = 0, n_fail = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: expected AR requests for a frame
  typedef struct { logic [ASIZE-1:0] addr; int len; } ar_t;
  ar_t exp_ar[$];
  int  exp_ar_n;

  task automatic build_model(logic [ASIZE-1:0] b, int vact, int beats);
    longint a;
    int off, n;
    exp_ar.delete();
    for (int l = 0; l < vact; l++) begin
      off = 0;
      while (off < beats) begin
        n = (beats - off > BURST_LEN) ? BURST_LEN : beats - off;
        a = (longint'(b) + longint'(l) * LINE_STEP + longint'(off) * BYTES) % (longint'(1) << ASIZE);
        exp_ar.push_back('{addr: ASIZE'(a), len: n});
        off += n;
      end
    end
    exp_ar_n = exp_ar.size();
  endtask

  // slave / monitor state
  int  rq[$];
  int  rbeat = 0, frame_beat = 0, ar_hs = 0, done_cnt = 0, ar_wait = 0;
  int  early_at = 0, resp_at = -1, rvalid_pct = 100, ar_hold = 0, cur_lbeats = 1;
  bit  chk_olast = 1'b1, ar_pend = 1'b0;
  logic [ASIZE-1:0] h_addr;
  logic [LSIZE-1:0] h_len;
  logic [AXI_DSIZE-1:0] rdata_drv;
  ar_t e;

  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      rbeat = 0; ar_pend = 1'b0; ar_wait = 0;
      axi.axi_arready = 1'b0; axi.axi_rvalid = 1'b0; axi.axi_rlast = 1'b0;
      axi.axi_rresp = 2'b00; axi.axi_rdata = '0;
    end else begin
      if (axi.axi_arvalid) begin
        axi.axi_arready = (ar_wait >= ar_hold);
        if (!axi.axi_arready) ar_wait++;
      end else axi.axi_arready = (ar_hold == 0);
      if (rq.size() != 0 && $urandom_range(99) < rvalid_pct) begin
        rdata_drv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        axi.axi_rvalid = 1'b1;
        axi.axi_rdata  = rdata_drv;
        axi.axi_rlast  = (early_at != 0) ? (rbeat == early_at - 1) : (rbeat == rq[0] - 1);
        axi.axi_rresp  = (frame_beat == resp_at) ? 2'b10 : 2'b00;
      end else begin
        axi.axi_rvalid = 1'b0; axi.axi_rlast = 1'b0; axi.axi_rresp = 2'b00;
      end
      #1;
      chk("rready", axi.axi_rready, rq.size() != 0);
      chk("ovalid", ovalid, axi.axi_rvalid);
      if (axi.axi_rvalid && axi.axi_rready) begin
        chk("odata_eq", odata == rdata_drv, 1);
        chk("ofirst", ofirst, frame_beat == 0);
        if (chk_olast) chk("olast", olast, ((frame_beat + 1) % cur_lbeats) == 0);
        frame_beat++; rbeat++;
        if (axi.axi_rlast) begin
          void'(rq.pop_front());
          rbeat = 0;
        end
      end
      if (axi.axi_arvalid) begin
        if (ar_pend) begin
          chk("ar_stable_addr", axi.axi_araddr, h_addr);
          chk("ar_stable_len", axi.axi_arlen, h_len);
        end
        if (axi.axi_arready) begin
          ar_hs++;
          chk("ar_one_outstanding", rq.size(), 0);
          chk("arid", axi.axi_arid, ID);
          chk("arsize", axi.axi_arsize, 5);
          chk("arburst", axi.axi_arburst, 1);
          chk("ar_count_le_model", ar_hs <= exp_ar_n, 1);
          if (exp_ar.size() != 0) begin
            e = exp_ar.pop_front();
            chk("araddr", axi.axi_araddr, e.addr);
            chk("arlen", axi.axi_arlen, e.len - 1);
          end
          rq.push_back(int'(axi.axi_arlen) + 1);
          ar_wait = 0; ar_pend = 1'b0;
        end else begin
          ar_pend = 1'b1; h_addr = axi.axi_araddr; h_len = axi.axi_arlen;
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic setup(logic [ASIZE-1:0] b, int vact, int beats);
    build_model(b, vact, beats);
    frame_beat = 0; ar_hs = 0; done_cnt = 0; cur_lbeats = (beats == 0) ? 1 : beats;
    baseaddr = b; vactive = 16'(vact); line_beats = 16'(beats);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_done(string tag, int exp_beats, logic exp_err);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 30000) begin step(); n++; end
    chk({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (4) step();
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_beats"}, frame_beat, exp_beats);
    chk({tag, "_ar_count"}, ar_hs, exp_ar_n);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  int cnt, vr, br;

  initial begin
    rst = 1'b1; start = 1'b0; baseaddr = '0; vactive = '0; line_beats = '0; fifo_space = 10'd512;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);    chk("rst_done", done, 0);     chk("rst_err", err, 0);
    chk("rst_arvalid", axi.axi_arvalid, 0); chk("rst_rready", axi.axi_rready, 0);
    chk("rst_ovalid", ovalid, 0); chk("rst_ofirst", ofirst, 0); chk("rst_olast", olast, 0);
    chk("rst_araddr", axi.axi_araddr, 0); chk("rst_arlen", axi.axi_arlen, 0);
    rst = 1'b0;
    step();

    // two lines of 300 beats, latency to first AR
    setup(29'h1000, 2, 300);
    pulse_start();
    chk("lat_c1_arvalid", axi.axi_arvalid, 0);
    chk("lat_c1_busy", busy, 1);
    step();
    chk("lat_c2_arvalid", axi.axi_arvalid, 1);
    chk("lat_c2_araddr", axi.axi_araddr, 29'h1000);
    chk("lat_c2_arlen", axi.axi_arlen, 127);
    wait_done("basic", 600, 1'b0);

    // gappy R, slow AR, start while busy is ignored
    setup(29'h0ABC_DE00, 3, 200);
    rvalid_pct = 60; ar_hold = 2;
    pulse_start();
    repeat (40) step();
    baseaddr = 29'h1; vactive = 16'd7; line_beats = 16'd5;
    pulse_start();
    wait_done("ignore_start", 600, 1'b0);

    // FIFO space gating
    rvalid_pct = 100; ar_hold = 0;
    setup(29'h40000, 1, 128);
    fifo_space = 10'd100;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("fifo_block_arvalid", axi.axi_arvalid, 0);
    end
    fifo_space = 10'd128;
    step();
    chk("fifo_release_arvalid", axi.axi_arvalid, 1);
    wait_done("fifo", 128, 1'b0);
    fifo_space = 10'd512;

    // arready held low five cycles
    setup(29'h80, 1, 64);
    ar_hold = 5;
    pulse_start();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (axi.axi_arvalid) cnt++;
    end
    chk("arvalid_cycles", cnt, 6);
    wait_done("arhold", 64, 1'b0);
    ar_hold = 0;

    // error response on one beat
    setup(29'h100000, 2, 128);
    resp_at = 50;
    pulse_start();
    wait_done("rresp", 256, 1'b1);
    resp_at = -1;

    // early rlast on beat 10 of 128
    setup(29'h200000, 1, 128);
    early_at = 10; chk_olast = 1'b0;
    pulse_start();
    wait_done("early_rlast", 10, 1'b1);
    early_at = 0; chk_olast = 1'b1;

    // err cleared by next start
    setup(29'h300000, 1, 5);
    pulse_start();
    chk("err_cleared", err, 0);
    wait_done("short", 5, 1'b0);

    // empty frames
    setup(29'h1000, 0, 300);
    pulse_start();
    chk("v0_c1_done", done, 0);
    step();
    chk("v0_c2_done", done, 1);
    chk("v0_c2_arvalid", axi.axi_arvalid, 0);
    step();
    chk("v0_c3_done", done, 0);
    repeat (3) step();
    chk("v0_ar_count", ar_hs, 0);
    chk("v0_done_pulses", done_cnt, 1);
    setup(29'h1000, 3, 0);
    pulse_start();
    step();
    chk("lb0_c2_done", done, 1);
    step();
    chk("lb0_ar_count", ar_hs, 0);

    // address wrap at 2^ASIZE
    setup(29'h1FFF_C000, 2, 300);
    rvalid_pct = 80;
    pulse_start();
    wait_done("wrap", 600, 1'b0);

    // reset during DATA, then replay
    rvalid_pct = 100;
    setup(29'h5000, 2, 300);
    pulse_start();
    cnt = 0;
    while (frame_beat < 20 && cnt < 2000) begin step(); cnt++; end
    chk("mid_reach_data", frame_beat >= 20, 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);     chk("mrst_done", done, 0);   chk("mrst_err", err, 0);
    chk("mrst_arvalid", axi.axi_arvalid, 0); chk("mrst_rready", axi.axi_rready, 0);
    chk("mrst_ovalid", ovalid, 0); chk("mrst_ofirst", ofirst, 0); chk("mrst_olast", olast, 0);
    chk("mrst_araddr", axi.axi_araddr, 0); chk("mrst_arlen", axi.axi_arlen, 0);
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_rst_arvalid", axi.axi_arvalid, 0);
    chk("post_rst_busy", busy, 0);
    setup(29'h5000, 2, 300);
    pulse_start();
    step();
    chk("replay_araddr", axi.axi_araddr, 29'h5000);
    wait_done("replay", 600, 1'b0);

    // randomized frames
    for (int k = 0; k < 4; k++) begin
      vr = $urandom_range(3, 1);
      br = $urandom_range(400, 1);
      fifo_space = 10'($urandom_range(1023, 128));
      rvalid_pct = $urandom_range(100, 40);
      ar_hold = $urandom_range(3, 0);
      setup(ASIZE'($urandom), vr, br);
      pulse_start();
      wait_done("random", vr * br, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
